// File: rtl/mld_scheduler.sv
// MLD scheduler: round-robin arbitration of two vector requesters onto one
// demodulator, trigger pacing, and readout credit / source tagging.
module mld_scheduler #(
    parameter int ISSUE_GAP  = 66,
    parameter int MAX_CREDIT = 31
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req_a,
    input  logic [159:0] i_y_hat_a,
    input  logic [319:0] i_r_a,
    output logic         o_gnt_a,
    input  logic         i_req_b,
    input  logic [159:0] i_y_hat_b,
    input  logic [319:0] i_r_b,
    output logic         o_gnt_b,
    output logic         o_dm_trig,
    output logic [159:0] o_dm_y_hat,
    output logic [319:0] o_dm_r,
    input  logic         i_dm_rd_vld,
    output logic         o_dm_rd_rdy,
    input  logic         i_sink_rdy,
    output logic         o_sink_vld,
    output logic         o_sink_src,
    output logic [2:0]   o_sink_idx,
    output logic         o_busy,
    output logic         o_err
);
    localparam int GW = $clog2(ISSUE_GAP);
    localparam logic [5:0] MAX_C = 6'(MAX_CREDIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic [5:0]    credit;
    logic [2:0]    sink_idx;
    logic [31:0]   tag_mem;
    logic [4:0]    wr_ptr;
    logic [4:0]    rd_ptr;
    logic          last_b;

    logic hs;
    logic pop;
    logic inc;
    logic can_grant;
    logic pick_b;

    assign o_dm_rd_rdy = i_sink_rdy;
    assign o_sink_vld  = i_dm_rd_vld;
    assign o_sink_src  = tag_mem[rd_ptr];
    assign o_sink_idx  = sink_idx;
    assign o_busy      = (state != IDLE) || (credit != '0);

    assign hs  = i_dm_rd_vld && i_sink_rdy;
    assign pop = hs && (sink_idx == 3'd7) && (credit != '0);
    assign inc = (state == ISSUE);

    assign can_grant = (state == IDLE) && (credit < MAX_C)
                     && (i_req_a || i_req_b);
    // On a tie the requester that was not granted last wins
    assign pick_b = i_req_b && (!i_req_a || !last_b);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            credit     <= '0;
            sink_idx   <= '0;
            tag_mem    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_b     <= 1'b1;
            o_gnt_a    <= 1'b0;
            o_gnt_b    <= 1'b0;
            o_dm_trig  <= 1'b0;
            o_err      <= 1'b0;
            o_dm_y_hat <= '0;
            o_dm_r     <= '0;
        end else begin
            o_gnt_a   <= 1'b0;
            o_gnt_b   <= 1'b0;
            o_dm_trig <= 1'b0;
            credit    <= credit + {5'd0, inc} - {5'd0, pop};
            if (hs) begin
                sink_idx <= sink_idx + 3'd1;
                if (credit == '0)
                    o_err <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 5'd1;
            unique case (state)
                IDLE: begin
                    if (can_grant) begin
                        o_gnt_a         <= !pick_b;
                        o_gnt_b         <= pick_b;
                        last_b          <= pick_b;
                        o_dm_y_hat      <= pick_b ? i_y_hat_b : i_y_hat_a;
                        o_dm_r          <= pick_b ? i_r_b : i_r_a;
                        tag_mem[wr_ptr] <= pick_b;
                        wr_ptr          <= wr_ptr + 5'd1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_dm_trig <= 1'b1;
                    gap_cnt   <= GW'(ISSUE_GAP - 2);
                    state     <= WAIT;
                end
                WAIT: begin
                    // Leave on the edge the count hits zero to keep exact spacing
                    if (gap_cnt <= GW'(1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mld_scheduler.sv
// Bench for mld_scheduler: directed scenarios plus random traffic, checked
// against a cycle-timeline reference model of grants, credit and tags.
module tb_mld_scheduler;
    localparam int GAP  = 66;
    localparam int MAXC = 31;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b0;
    logic         i_req_a = 1'b0;
    logic [159:0] i_y_hat_a = '0;
    logic [319:0] i_r_a = '0;
    logic         o_gnt_a;
    logic         i_req_b = 1'b0;
    logic [159:0] i_y_hat_b = '0;
    logic [319:0] i_r_b = '0;
    logic         o_gnt_b;
    logic         o_dm_trig;
    logic [159:0] o_dm_y_hat;
    logic [319:0] o_dm_r;
    logic         i_dm_rd_vld = 1'b0;
    logic         o_dm_rd_rdy;
    logic         i_sink_rdy = 1'b0;
    logic         o_sink_vld;
    logic         o_sink_src;
    logic [2:0]   o_sink_idx;
    logic         o_busy;
    logic         o_err;

    always #5 i_clk = ~i_clk;

    mld_scheduler #(.ISSUE_GAP(GAP), .MAX_CREDIT(MAXC)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_a(i_req_a), .i_y_hat_a(i_y_hat_a), .i_r_a(i_r_a),
        .o_gnt_a(o_gnt_a),
        .i_req_b(i_req_b), .i_y_hat_b(i_y_hat_b), .i_r_b(i_r_b),
        .o_gnt_b(o_gnt_b),
        .o_dm_trig(o_dm_trig), .o_dm_y_hat(o_dm_y_hat), .o_dm_r(o_dm_r),
        .i_dm_rd_vld(i_dm_rd_vld), .o_dm_rd_rdy(o_dm_rd_rdy),
        .i_sink_rdy(i_sink_rdy), .o_sink_vld(o_sink_vld),
        .o_sink_src(o_sink_src), .o_sink_idx(o_sink_idx),
        .o_busy(o_busy), .o_err(o_err)
    );

    int vectors = 0;
    int miscompares = 0;

    int n = 0;
    int last_g = 0;
    bit have_g;
    int credit_m;
    bit tags_m[$];
    bit last_b_m;
    int idx_m;
    bit err_m;
    logic [159:0] exp_y;
    logic [319:0] exp_r;
    bit exp_ga, exp_gb, exp_trig, exp_busy;
    int trig_times[$];
    bit obs_order[$];

    task automatic check(input string tag, input logic [319:0] got,
                         input logic [319:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] rnd160();
        logic [159:0] v;
        for (int i = 0; i < 5; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        have_g   = 0;
        credit_m = 0;
        tags_m.delete();
        last_b_m = 1;
        idx_m    = 0;
        err_m    = 0;
        exp_y    = '0;
        exp_r    = '0;
        exp_ga   = 0;
        exp_gb   = 0;
        exp_trig = 0;
        exp_busy = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at next negedge
    task automatic tick();
        bit hs, ga, gb, iss, pop;
        int cpre;
        #1;
        check("rd_rdy", 320'(o_dm_rd_rdy), 320'(i_sink_rdy));
        check("sink_vld", 320'(o_sink_vld), 320'(i_dm_rd_vld));
        check("sink_idx", 320'(o_sink_idx), 320'(idx_m));
        if (tags_m.size() != 0)
            check("sink_src", 320'(o_sink_src), 320'(tags_m[0]));
        n++;
        cpre = credit_m;
        hs   = i_dm_rd_vld && i_sink_rdy;
        iss  = have_g && (n == last_g + 1);
        pop  = 0;
        if (hs) begin
            if (cpre == 0) err_m = 1;
            else if (idx_m == 7) pop = 1;
            idx_m = (idx_m + 1) % 8;
        end
        ga = 0;
        gb = 0;
        if ((!have_g || n - last_g >= GAP) && cpre < MAXC
            && (i_req_a || i_req_b)) begin
            gb = (i_req_a && i_req_b) ? !last_b_m : i_req_b;
            ga = !gb;
            exp_y = gb ? i_y_hat_b : i_y_hat_a;
            exp_r = gb ? i_r_b : i_r_a;
            tags_m.push_back(gb);
            last_b_m = gb;
            last_g = n;
            have_g = 1;
        end
        if (pop) void'(tags_m.pop_front());
        credit_m = cpre + (iss ? 1 : 0) - (pop ? 1 : 0);
        exp_ga   = ga;
        exp_gb   = gb;
        exp_trig = iss;
        exp_busy = (have_g && (n - last_g <= GAP - 2)) || (credit_m != 0);
        @(posedge i_clk);
        #1;
        check("gnt_a", 320'(o_gnt_a), 320'(exp_ga));
        check("gnt_b", 320'(o_gnt_b), 320'(exp_gb));
        check("trig", 320'(o_dm_trig), 320'(exp_trig));
        check("dm_y_hat", 320'(o_dm_y_hat), 320'(exp_y));
        check("dm_r", o_dm_r, exp_r);
        check("busy", 320'(o_busy), 320'(exp_busy));
        check("err", 320'(o_err), 320'(err_m));
        if (o_dm_trig) trig_times.push_back(n);
        if (o_gnt_a || o_gnt_b) obs_order.push_back(o_gnt_b);
        @(negedge i_clk);
    endtask

    task automatic refresh(input bit keep_a, input bit keep_b);
        if (exp_ga) begin
            i_req_a   = keep_a;
            i_y_hat_a = rnd160();
            i_r_a     = rnd320();
        end
        if (exp_gb) begin
            i_req_b   = keep_b;
            i_y_hat_b = rnd160();
            i_r_b     = rnd320();
        end
    endtask

    // Entered at a negedge; asserts reset between edges, releases at a negedge
    task automatic do_reset();
        i_req_a = 0;
        i_req_b = 0;
        i_dm_rd_vld = 0;
        i_sink_rdy = 0;
        #3 i_reset = 1;
        #1;
        check("rst_gnt_a", 320'(o_gnt_a), 320'(0));
        check("rst_gnt_b", 320'(o_gnt_b), 320'(0));
        check("rst_trig", 320'(o_dm_trig), 320'(0));
        check("rst_err", 320'(o_err), 320'(0));
        check("rst_busy", 320'(o_busy), 320'(0));
        check("rst_idx", 320'(o_sink_idx), 320'(0));
        check("rst_y_hat", 320'(o_dm_y_hat), 320'(0));
        check("rst_r", o_dm_r, 320'(0));
        model_reset();
        @(negedge i_clk);
        i_reset = 0;
    endtask

    task automatic check_spacing(input string tag, input int cnt);
        check({tag, "_count"}, 320'(trig_times.size()), 320'(cnt));
        for (int i = 1; i < trig_times.size(); i++)
            check(tag, 320'(trig_times[i] - trig_times[i-1]), 320'(GAP));
    endtask

    initial begin
        int w;
        model_reset();
        @(negedge i_clk);
        do_reset();

        // Single vector from A at cycle 10, then eight reads
        repeat (9) tick();
        i_req_a = 1;
        i_y_hat_a = rnd160();
        i_r_a = rnd320();
        tick();
        check("s1_gnt_a", 320'(o_gnt_a), 320'(1));
        i_req_a = 0;
        tick();
        check("s1_trig", 320'(o_dm_trig), 320'(1));
        i_sink_rdy = 1;
        i_dm_rd_vld = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("s1_src", 320'(o_sink_src), 320'(0));
            check("s1_idx", 320'(o_sink_idx), 320'(i));
            tick();
        end
        i_dm_rd_vld = 0;
        repeat (70) tick();
        check("s1_busy_clear", 320'(o_busy), 320'(0));

        // Tie from reset: A,B,A,B with exact spacing
        do_reset();
        trig_times.delete();
        obs_order.delete();
        i_req_a = 1;
        i_req_b = 1;
        repeat (4 * GAP) begin
            tick();
            refresh(1, 1);
        end
        check_spacing("tie_space", 4);
        check("tie_grants", 320'(obs_order.size()), 320'(4));
        for (int i = 0; i < obs_order.size(); i++)
            check("tie_order", 320'(obs_order[i]), 320'(i % 2));

        // Credit cap: 31 issued with no readout, then regrant after one vector
        do_reset();
        obs_order.delete();
        i_req_a = 1;
        i_y_hat_a = rnd160();
        i_r_a = rnd320();
        repeat (32 * GAP + 20) begin
            tick();
            refresh(1, 0);
        end
        check("cap_grants", 320'(obs_order.size()), 320'(MAXC));
        i_sink_rdy = 1;
        i_dm_rd_vld = 1;
        repeat (8) tick();
        i_dm_rd_vld = 0;
        tick();
        check("cap_regrant", 320'(o_gnt_a), 320'(1));
        i_req_a = 0;

        // Eighth read lands on the ISSUE edge of the next vector
        do_reset();
        i_req_a = 1;
        i_y_hat_a = rnd160();
        i_r_a = rnd320();
        tick();
        i_req_a = 0;
        tick();
        i_sink_rdy = 1;
        i_dm_rd_vld = 1;
        repeat (7) tick();
        i_dm_rd_vld = 0;
        i_req_a = 1;
        i_y_hat_a = rnd160();
        i_r_a = rnd320();
        w = 0;
        while (!exp_ga && w < 100) begin
            tick();
            w++;
        end
        check("sim_grant_bound", 320'(w < 100), 320'(1));
        i_req_a = 0;
        i_dm_rd_vld = 1;
        tick();
        check("sim_trig", 320'(o_dm_trig), 320'(1));
        repeat (8) tick();
        i_dm_rd_vld = 0;
        repeat (70) tick();
        check("sim_busy_clear", 320'(o_busy), 320'(0));
        check("sim_no_err", 320'(o_err), 320'(0));

        // Underflow read, sticky error
        i_dm_rd_vld = 1;
        tick();
        i_dm_rd_vld = 0;
        check("uf_err", 320'(o_err), 320'(1));
        repeat (5) tick();
        check("uf_sticky", 320'(o_err), 320'(1));

        // Reset while the gap counter reads 20
        do_reset();
        i_req_a = 1;
        i_y_hat_a = rnd160();
        i_r_a = rnd320();
        tick();
        i_req_a = 0;
        while (n < last_g + 45) tick();
        check("wr_busy_pre", 320'(o_busy), 320'(1));
        do_reset();
        trig_times.delete();
        obs_order.delete();
        i_req_a = 1;
        i_req_b = 1;
        i_y_hat_a = rnd160();
        i_r_a = rnd320();
        repeat (2 * GAP + 5) begin
            tick();
            refresh(1, 1);
        end
        check_spacing("wr_space", 3);
        check("wr_first_a", 320'(obs_order[0]), 320'(0));

        // Random traffic
        do_reset();
        i_req_a = 0;
        i_req_b = 0;
        repeat (4000) begin
            if (!i_req_a && $urandom_range(3) == 0) begin
                i_req_a = 1;
                i_y_hat_a = rnd160();
                i_r_a = rnd320();
            end
            if (!i_req_b && $urandom_range(3) == 0) begin
                i_req_b = 1;
                i_y_hat_b = rnd160();
                i_r_b = rnd320();
            end
            i_sink_rdy = $urandom_range(1);
            i_dm_rd_vld = (credit_m > 0) ? ($urandom_range(1) == 1)
                                         : ($urandom_range(199) == 0);
            tick();
            refresh(0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mld_scheduler.md
MLD_SCHEDULER -- requirements
Module: mld_scheduler

Interface
REQ-001 Parameters (name, default, meaning):
- ISSUE_GAP, 66: minimum cycles between successive o_dm_trig pulses; covers demodulator compute plus margin.
- MAX_CREDIT, 31: maximum vectors issued but not fully read out; kept below 32 so the demodulator's 256-bit buffer never wraps onto its read pointer.
REQ-002 Ports (name, direction, width, meaning):
- i_clk, in, 1: clock.
- i_reset, in, 1: asynchronous, active-high reset.
- i_req_a, in, 1: requester A holds a vector.
- i_y_hat_a, in, 160: requester A y_hat.
- i_r_a, in, 320: requester A R matrix.
- o_gnt_a, out, 1: one-cycle accept pulse to requester A.
- i_req_b, in, 1: requester B holds a vector.
- i_y_hat_b, in, 160: requester B y_hat.
- i_r_b, in, 320: requester B R matrix.
- o_gnt_b, out, 1: one-cycle accept pulse to requester B.
- o_dm_trig, out, 1: demodulator start pulse.
- o_dm_y_hat, out, 160: registered y_hat to the demodulator.
- o_dm_r, out, 320: registered R to the demodulator.
- i_dm_rd_vld, in, 1: demodulator output bit valid.
- o_dm_rd_rdy, out, 1: ready to the demodulator.
- i_sink_rdy, in, 1: downstream consumer ready.
- o_sink_vld, out, 1: bit valid to the consumer.
- o_sink_src, out, 1: source of the current bit (0 = A, 1 = B).
- o_sink_idx, out, 3: bit index within the vector, 0..7.
- o_busy, out, 1: state is not IDLE, or credit is nonzero.
- o_err, out, 1: sticky underflow flag.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-004 In IDLE, when credit < MAX_CREDIT and i_req_a or i_req_b is high, the block SHALL pulse the winner's grant for one cycle, latch its y_hat and R into o_dm_y_hat/o_dm_r on the same edge, push its source bit into the tag FIFO, and go to ISSUE.
REQ-005 Arbitration SHALL be round-robin on the last-granted pointer: when both request, grant the one not last granted; a single requester is always granted; both grants SHALL never be high together.
REQ-006 Requesters SHALL hold req and data stable until granted; the block SHALL only sample data in the grant cycle.
REQ-007 In ISSUE, o_dm_trig SHALL be high for exactly one cycle, o_dm_y_hat/o_dm_r SHALL stay stable, credit SHALL increment, the gap counter SHALL load ISSUE_GAP-2, and the FSM SHALL go to WAIT.
REQ-008 In WAIT, the gap counter SHALL decrement each cycle and the FSM SHALL go to IDLE when it reaches 0.
- Rising edges of o_dm_trig are therefore at least ISSUE_GAP cycles apart.
- o_dm_y_hat/o_dm_r SHALL hold until the next grant.
REQ-009 Readout pass-through:
- o_dm_rd_rdy = i_sink_rdy.
- o_sink_vld = i_dm_rd_vld.
- A read handshake is i_dm_rd_vld && i_sink_rdy.
REQ-010 o_sink_idx SHALL increment on each read handshake and wrap 7 -> 0; o_sink_src SHALL equal the tag FIFO head.
REQ-011 On a handshake with o_sink_idx == 7, the block SHALL pop the tag FIFO and decrement credit.
- A simultaneous ISSUE increment and pop decrement SHALL leave credit unchanged.
REQ-012 When credit == MAX_CREDIT, IDLE SHALL not grant; pending requests wait with no grant pulse.
REQ-013 Tag FIFO: depth 32, 1 bit wide; push on grant, pop per REQ-011; it can never overflow because credit is capped.
REQ-014 A read handshake while credit == 0 SHALL set o_err, with no pop and no credit change; o_err clears only on reset.
REQ-015 Credit SHALL be 6 bits wide and saturate at 0 on underflow.

Reset
REQ-016 i_reset high SHALL asynchronously force, at any time including mid-WAIT:
- FSM = IDLE; gap counter, credit and o_sink_idx = 0.
- Tag FIFO empty; last-granted pointer = B, so A wins the first tie.
- o_gnt_a, o_gnt_b, o_dm_trig, o_err, o_busy = 0.
- o_dm_y_hat = 0 and o_dm_r = 0.
REQ-017 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge at which a request is sampled in IDLE.

Verification
REQ-018 Scenarios:
- Single vector: A requests at cycle 10 -> o_gnt_a at 10, o_dm_trig at 11, credit 1; 8 reads with i_sink_rdy=1 -> o_sink_src=0, idx 0..7, credit returns to 0, o_busy=0.
- Tie: A and B request continuously from reset -> grant order A,B,A,B; trig spacing exactly 66 cycles.
- Credit cap: issue 31 vectors with i_sink_rdy=0 -> no 32nd grant; after 8 reads, credit 30 -> next grant within 1 cycle of IDLE.
- Simultaneous: 8th read handshake in the same cycle as ISSUE -> credit unchanged.
- Underflow: i_dm_rd_vld=1 with credit 0 -> o_err=1 and sticky.
- Reset at WAIT count 20 -> all outputs at reset values; a new request is granted normally with the full ISSUE_GAP spacing.
